// File: rtl/branch_tracker.sv
// Tracks in-flight conditional branches: captures predictor results into an
// in-order queue, trains the predictor on resolution and flushes on mispredict.
module branch_tracker #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     br_fetch,
   output logic                     fetch_stall,
   output logic                     pred_req,
   input  logic                     pred_in,
   output logic                     pred_valid,
   output logic                     pred_out,
   input  logic                     br_resolve,
   input  logic                     br_taken,
   output logic                     upd_result,
   output logic                     upd_taken,
   output logic                     mispredict,
   output logic [$clog2(DEPTH):0]   occupancy,
   output logic [CNT_W-1:0]         n_resolved,
   output logic [CNT_W-1:0]         n_mispred,
   output logic                     err_underflow
);

   localparam int PW = $clog2(DEPTH);
   localparam int OW = PW + 1;

   logic [DEPTH-1:0] queue_q, queue_d;
   logic [PW-1:0]    head_q, head_d;
   logic [PW-1:0]    tail_q, tail_d;
   logic [OW-1:0]    count_q, count_d;
   logic             pend_q, pend_d;
   logic             mispredict_q, mispredict_d;
   logic [CNT_W-1:0] n_res_q, n_res_d;
   logic [CNT_W-1:0] n_mis_q, n_mis_d;
   logic             err_q, err_d;

   logic [OW-1:0]    occ_s;
   logic             empty_s;
   logic             full_s;
   logic             res_ok_s;
   logic             flush_now_s;
   logic             accept_s;

   // Control decode: a same-cycle pop never frees a slot for a fetch.
   always_comb begin
      occ_s       = count_q + OW'(pend_q);
      empty_s     = (count_q == {OW{1'b0}});
      full_s      = (occ_s >= OW'(DEPTH));
      res_ok_s    = br_resolve & ~empty_s;
      flush_now_s = res_ok_s & (queue_q[head_q] != br_taken);
      accept_s    = br_fetch & ~full_s & ~flush_now_s;
   end

   // Queue, pending capture, statistics and error next-state.
   always_comb begin
      queue_d      = queue_q;
      head_d       = head_q;
      tail_d       = tail_q;
      count_d      = count_q;
      pend_d       = accept_s;
      mispredict_d = flush_now_s;
      n_res_d      = n_res_q;
      n_mis_d      = n_mis_q;
      err_d        = err_q | (br_resolve & empty_s);
      if (flush_now_s) begin
         count_d = {OW{1'b0}};
         head_d  = tail_q;
         pend_d  = 1'b0;
      end else begin
         if (pend_q) begin
            queue_d[tail_q] = pred_in;
            tail_d          = tail_q + PW'(1);
         end else begin
            tail_d = tail_q;
         end
         if (res_ok_s) begin
            head_d = head_q + PW'(1);
         end else begin
            head_d = head_q;
         end
         count_d = count_q + OW'(pend_q) - OW'(res_ok_s);
      end
      if (res_ok_s && (n_res_q != {CNT_W{1'b1}})) begin
         n_res_d = n_res_q + CNT_W'(1);
      end else begin
         n_res_d = n_res_q;
      end
      if (flush_now_s && (n_mis_q != {CNT_W{1'b1}})) begin
         n_mis_d = n_mis_q + CNT_W'(1);
      end else begin
         n_mis_d = n_mis_q;
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         queue_q      <= {DEPTH{1'b0}};
         head_q       <= {PW{1'b0}};
         tail_q       <= {PW{1'b0}};
         count_q      <= {OW{1'b0}};
         pend_q       <= 1'b0;
         mispredict_q <= 1'b0;
         n_res_q      <= {CNT_W{1'b0}};
         n_mis_q      <= {CNT_W{1'b0}};
         err_q        <= 1'b0;
      end else begin
         queue_q      <= queue_d;
         head_q       <= head_d;
         tail_q       <= tail_d;
         count_q      <= count_d;
         pend_q       <= pend_d;
         mispredict_q <= mispredict_d;
         n_res_q      <= n_res_d;
         n_mis_q      <= n_mis_d;
         err_q        <= err_d;
      end
   end

   // Output drive; the prediction is forwarded while its capture is pending.
   always_comb begin
      fetch_stall   = br_fetch & (full_s | flush_now_s);
      pred_req      = accept_s;
      pred_valid    = pend_q;
      pred_out      = pend_q & pred_in;
      upd_result    = res_ok_s;
      upd_taken     = br_taken;
      mispredict    = mispredict_q;
      occupancy     = occ_s;
      n_resolved    = n_res_q;
      n_mispred     = n_mis_q;
      err_underflow = err_q;
   end

endmodule
